// File: rtl/stepdir_position_tracker_pkg.sv
// Shared definitions for the step/dir position tracker: parameter defaults,
// line encodings and the snapshot FSM state type.
package stepdir_position_tracker_pkg;

    localparam int DEF_POS_W     = 24;
    localparam int DEF_FILT_CYC  = 4;
    localparam int DEF_DIR_SETUP = 2;
    localparam int DEF_IDLE_CYC  = 65535;

    // Idle counter width; IDLE_CYC must stay below 2^20
    localparam int IDLE_CNT_W = 20;

    // Step line rests high, a step is a falling edge
    localparam logic PUL_IDLE = 1'b1;

    // Direction encoding: 0 counts up, 1 counts down
    localparam logic DIR_POS = 1'b0;
    localparam logic DIR_NEG = 1'b1;

    typedef enum logic {
        SNAP_IDLE = 1'b0,
        SNAP_ACK  = 1'b1
    } snap_state_t;

endpackage

// File: rtl/stepdir_position_tracker_if.sv
// Snapshot request/acknowledge bus: the requester raises snap_req and holds it
// until it has read snap_x/snap_y while snap_ack is high.
interface stepdir_position_tracker_if
    import stepdir_position_tracker_pkg::*;
#(
    parameter int POS_W = DEF_POS_W
);

    logic             snap_req;
    logic             snap_ack;
    logic [POS_W-1:0] snap_x;
    logic [POS_W-1:0] snap_y;

    modport master (output snap_req, input snap_ack, input snap_x, input snap_y);
    modport slave  (input snap_req, output snap_ack, output snap_x, output snap_y);

endinterface

// File: rtl/stepdir_axis_decoder.sv
// One axis of the step/dir receiver: synchronises and debounces pul/dir,
// detects the step edge, checks dir setup time and keeps the signed position.
module stepdir_axis_decoder
    import stepdir_position_tracker_pkg::*;
#(
    parameter int POS_W     = DEF_POS_W,
    parameter int FILT_CYC  = DEF_FILT_CYC,
    parameter int DIR_SETUP = DEF_DIR_SETUP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             pul_in,
    input  logic             dir_in,
    output logic             step_evt,
    output logic             err_evt,
    output logic             ovf_evt,
    output logic [POS_W-1:0] pos
);

    localparam int FCW = $clog2(FILT_CYC + 1);
    localparam int AGW = $clog2(DIR_SETUP + 2);
    localparam logic [FCW-1:0]   FILT_LAST = FCW'(FILT_CYC - 1);
    localparam logic [AGW-1:0]   AGE_MAX   = AGW'(DIR_SETUP);
    localparam logic [POS_W-1:0] POS_MAX   = {1'b0, {(POS_W-1){1'b1}}};
    localparam logic [POS_W-1:0] POS_MIN   = {1'b1, {(POS_W-1){1'b0}}};

    logic [1:0]     pul_sync;
    logic [1:0]     dir_sync;
    logic           pul_filt;
    logic           pul_filt_d;
    logic [FCW-1:0] pul_cnt;
    logic           dir_filt;
    logic [FCW-1:0] dir_cnt;
    logic [AGW-1:0] dir_age;

    // Two-flop synchronisers for the asynchronous pul/dir lines
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pul_sync <= {2{PUL_IDLE}};
            dir_sync <= {2{DIR_POS}};
        end else begin
            pul_sync <= {pul_sync[0], pul_in};
            dir_sync <= {dir_sync[0], dir_in};
        end
    end

    // Pulse filter: accept a new level after FILT_CYC consecutive differing samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pul_filt <= PUL_IDLE;
            pul_cnt  <= '0;
        end else if (pul_sync[1] == pul_filt) begin
            pul_cnt <= '0;
        end else if (pul_cnt == FILT_LAST) begin
            pul_filt <= pul_sync[1];
            pul_cnt  <= '0;
        end else begin
            pul_cnt <= pul_cnt + FCW'(1);
        end
    end

    // Direction filter plus age of the filtered level for the setup check
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir_filt <= DIR_POS;
            dir_cnt  <= '0;
            dir_age  <= AGE_MAX;
        end else begin
            if (dir_sync[1] == dir_filt) begin
                dir_cnt <= '0;
            end else if (dir_cnt == FILT_LAST) begin
                dir_filt <= dir_sync[1];
                dir_cnt  <= '0;
            end else begin
                dir_cnt <= dir_cnt + FCW'(1);
            end
            if ((dir_sync[1] != dir_filt) && (dir_cnt == FILT_LAST)) begin
                dir_age <= '0;
            end else if (dir_age != AGE_MAX) begin
                dir_age <= dir_age + AGW'(1);
            end
        end
    end

    // Delayed filtered pulse for falling-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pul_filt_d <= PUL_IDLE;
        end else begin
            pul_filt_d <= pul_filt;
        end
    end

    assign step_evt = pul_filt_d & ~pul_filt;
    assign err_evt  = step_evt && (dir_age < AGE_MAX);
    assign ovf_evt  = step_evt && ((dir_filt == DIR_NEG) ? (pos == POS_MIN) : (pos == POS_MAX));

    // Position counter; clear takes priority over a coincident step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos <= '0;
        end else if (clr) begin
            pos <= '0;
        end else if (step_evt) begin
            pos <= (dir_filt == DIR_NEG) ? (pos - POS_W'(1)) : (pos + POS_W'(1));
        end
    end

endmodule

// File: rtl/stepdir_position_tracker.sv
// Two-axis step/dir receiver: decodes X/Y positions, keeps sticky error and
// overflow flags, reports idle/home and serves an atomic position snapshot.
module stepdir_position_tracker
    import stepdir_position_tracker_pkg::*;
#(
    parameter int POS_W     = DEF_POS_W,
    parameter int FILT_CYC  = DEF_FILT_CYC,
    parameter int DIR_SETUP = DEF_DIR_SETUP,
    parameter int IDLE_CYC  = DEF_IDLE_CYC
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clr,
    input  logic                          pul1_in,
    input  logic                          dir1_in,
    input  logic                          pul2_in,
    input  logic                          dir2_in,
    stepdir_position_tracker_if.slave     snap_bus,
    output logic [POS_W-1:0]              pos_x,
    output logic [POS_W-1:0]              pos_y,
    output logic                          step_err,
    output logic                          ovf,
    output logic                          idle,
    output logic                          home
);

    localparam logic [IDLE_CNT_W-1:0] IDLE_MAX = IDLE_CNT_W'(IDLE_CYC);

    logic                  step_x;
    logic                  step_y;
    logic                  err_x;
    logic                  err_y;
    logic                  ovf_x;
    logic                  ovf_y;
    logic [IDLE_CNT_W-1:0] idle_cnt;
    snap_state_t           state;

    stepdir_axis_decoder #(
        .POS_W     (POS_W),
        .FILT_CYC  (FILT_CYC),
        .DIR_SETUP (DIR_SETUP)
    ) u_axis_x (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .pul_in   (pul1_in),
        .dir_in   (dir1_in),
        .step_evt (step_x),
        .err_evt  (err_x),
        .ovf_evt  (ovf_x),
        .pos      (pos_x)
    );

    stepdir_axis_decoder #(
        .POS_W     (POS_W),
        .FILT_CYC  (FILT_CYC),
        .DIR_SETUP (DIR_SETUP)
    ) u_axis_y (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .pul_in   (pul2_in),
        .dir_in   (dir2_in),
        .step_evt (step_y),
        .err_evt  (err_y),
        .ovf_evt  (ovf_y),
        .pos      (pos_y)
    );

    // Cycles since the last step on either axis, saturating at IDLE_CYC
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if (clr || step_x || step_y) begin
            idle_cnt <= '0;
        end else if (idle_cnt != IDLE_MAX) begin
            idle_cnt <= idle_cnt + IDLE_CNT_W'(1);
        end
    end

    assign idle = (idle_cnt == IDLE_MAX);
    assign home = idle && (pos_x == '0) && (pos_y == '0);

    // Sticky setup-violation and wrap flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_err <= 1'b0;
            ovf      <= 1'b0;
        end else if (clr) begin
            step_err <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            step_err <= step_err | err_x | err_y;
            ovf      <= ovf | ovf_x | ovf_y;
        end
    end

    // Snapshot handshake: capture on a fresh request, hold until it drops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= SNAP_IDLE;
            snap_bus.snap_ack <= 1'b0;
            snap_bus.snap_x   <= '0;
            snap_bus.snap_y   <= '0;
        end else begin
            case (state)
                SNAP_IDLE: begin
                    if (snap_bus.snap_req) begin
                        snap_bus.snap_x   <= pos_x;
                        snap_bus.snap_y   <= pos_y;
                        snap_bus.snap_ack <= 1'b1;
                        state             <= SNAP_ACK;
                    end
                end
                SNAP_ACK: begin
                    if (!snap_bus.snap_req) begin
                        snap_bus.snap_ack <= 1'b0;
                        state             <= SNAP_IDLE;
                    end
                end
                default: begin
                    snap_bus.snap_ack <= 1'b0;
                    state             <= SNAP_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stepdir_position_tracker.sv
// Directed bench for the step/dir position tracker with a queue-based scoreboard.
module tb_stepdir_position_tracker;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        clr;
    logic        pul1, dir1, pul2, dir2;
    logic        pul_w, dir_w;
    logic [23:0] pos_x, pos_y;
    logic        step_err, ovf, idle, home;
    logic [3:0]  pos_x4, pos_y4;
    logic        step_err4, ovf4, idle4, home4;

    logic [23:0] mx, my;
    logic [3:0]  mw;
    exp_t        sb_q[$];
    int          tests_run;
    int          fails;
    int          n;

    stepdir_position_tracker_if #(.POS_W(24)) snap_bus ();
    stepdir_position_tracker_if #(.POS_W(4))  snap_bus4 ();

    stepdir_position_tracker #(
        .POS_W(24), .FILT_CYC(4), .DIR_SETUP(2), .IDLE_CYC(100)
    ) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .pul1_in(pul1), .dir1_in(dir1), .pul2_in(pul2), .dir2_in(dir2),
        .snap_bus(snap_bus),
        .pos_x(pos_x), .pos_y(pos_y),
        .step_err(step_err), .ovf(ovf), .idle(idle), .home(home)
    );

    stepdir_position_tracker #(
        .POS_W(4), .FILT_CYC(4), .DIR_SETUP(2), .IDLE_CYC(100)
    ) dut4 (
        .clk(clk), .rst(rst), .clr(clr),
        .pul1_in(pul_w), .dir1_in(dir_w), .pul2_in(1'b1), .dir2_in(1'b0),
        .snap_bus(snap_bus4),
        .pos_x(pos_x4), .pos_y(pos_y4),
        .step_err(step_err4), .ovf(ovf4), .idle(idle4), .home(home4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    task automatic sb_push(input string tag, input logic [31:0] value);
        exp_t e;
        e.tag = tag;
        e.exp = value;
        sb_q.push_back(e);
    endtask

    task automatic checkOutput(input logic [31:0] observed);
        exp_t e;
        tests_run++;
        if (sb_q.size() == 0) begin
            fails++;
            $error("[TB] FAIL scoreboard_empty observed=%0h expected=none", observed);
        end else begin
            e = sb_q.pop_front();
            assert (observed === e.exp) else begin
                fails++;
                $error("[TB] FAIL %s observed=%0h expected=%0h", e.tag, observed, e.exp);
            end
        end
    endtask

    task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        sb_push(tag, expected);
        checkOutput(observed);
    endtask

    function automatic logic [31:0] observe(input int axis);
        case (axis)
            0:       return 32'(pos_x);
            1:       return 32'(pos_y);
            default: return 32'(pos_x4);
        endcase
    endfunction

    // One pulse on an axis (0=X, 1=Y, 2=X of the 4-bit instance); expectation queued at drive time
    task automatic applyStimulus(input int axis, input logic d, input int low, input int high);
        case (axis)
            0:       dir1  = d;
            1:       dir2  = d;
            default: dir_w = d;
        endcase
        tick(4);
        case (axis)
            0: begin
                pul1 = 1'b0;
                if (low >= 4) mx = d ? mx - 24'd1 : mx + 24'd1;
                sb_push("pos_x", 32'(mx));
            end
            1: begin
                pul2 = 1'b0;
                if (low >= 4) my = d ? my - 24'd1 : my + 24'd1;
                sb_push("pos_y", 32'(my));
            end
            default: begin
                pul_w = 1'b0;
                if (low >= 4) mw = d ? mw - 4'd1 : mw + 4'd1;
                sb_push("pos_w", 32'(mw));
            end
        endcase
        tick(low);
        case (axis)
            0:       pul1  = 1'b1;
            1:       pul2  = 1'b1;
            default: pul_w = 1'b1;
        endcase
        tick(high);
        checkOutput(observe(axis));
    endtask

    initial begin
        tests_run = 0;
        fails     = 0;
        mx = '0; my = '0; mw = '0;
        rst = 1'b1; clr = 1'b0;
        pul1 = 1'b1; dir1 = 1'b0; pul2 = 1'b1; dir2 = 1'b0;
        pul_w = 1'b1; dir_w = 1'b0;
        snap_bus.snap_req  = 1'b0;
        snap_bus4.snap_req = 1'b0;

        // Reset state and idle/home after quiet inputs
        tick(3);
        checkVal("rst_pos_x", 32'(pos_x), 32'd0);
        checkVal("rst_pos_y", 32'(pos_y), 32'd0);
        checkVal("rst_snap", {7'd0, snap_bus.snap_ack, snap_bus.snap_x}, 32'd0);
        checkVal("rst_flags", {28'd0, step_err, ovf, idle, home}, 32'd0);
        rst = 1'b0;
        tick(99);
        checkVal("idle_at_99", {31'd0, idle}, 32'd0);
        tick(1);
        checkVal("idle_at_100", {30'd0, idle, home}, 32'b11);

        // First step latency from raw falling edge
        pul1 = 1'b0;
        n = 0;
        while (pos_x == 24'd0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkVal("latency", 32'(n), 32'd7);
        @(negedge clk);
        pul1 = 1'b1;
        tick(12);
        mx = 24'd1;
        checkVal("pos_x_first", 32'(pos_x), 32'(mx));

        // Counting up then down on X
        for (int i = 0; i < 9; i++) applyStimulus(0, 1'b0, 8, 12);
        for (int i = 0; i < 5; i++) applyStimulus(0, 1'b1, 8, 12);
        checkVal("pos_y_after_x", 32'(pos_y), 32'd0);
        checkVal("step_err_clean", {31'd0, step_err}, 32'd0);

        // Glitch rejection on Y: 3 cycles dropped, 4 cycles counted
        applyStimulus(1, 1'b0, 3, 12);
        applyStimulus(1, 1'b0, 4, 12);

        // Direction setup violation one cycle before the step
        dir1 = 1'b0;
        tick(10);
        dir1 = 1'b1;
        tick(1);
        pul1 = 1'b0;
        mx = mx - 24'd1;
        sb_push("pos_x_setup_viol", 32'(mx));
        tick(8);
        pul1 = 1'b1;
        tick(12);
        checkOutput(32'(pos_x));
        checkVal("step_err_set", {31'd0, step_err}, 32'd1);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        mx = '0; my = '0;
        checkVal("clr_flags", {30'd0, step_err, ovf}, 32'd0);
        checkVal("clr_pos", {pos_x[15:0], pos_y[15:0]}, 32'd0);

        // Direction exactly DIR_SETUP cycles before the step is legal
        dir1 = 1'b0;
        tick(2);
        pul1 = 1'b0;
        mx = mx + 24'd1;
        sb_push("pos_x_setup_ok", 32'(mx));
        tick(8);
        pul1 = 1'b1;
        tick(12);
        checkOutput(32'(pos_x));
        checkVal("step_err_setup_ok", {31'd0, step_err}, 32'd0);

        // Rectangle returns to origin, then home
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        mx = '0;
        for (int i = 0; i < 3; i++) applyStimulus(0, 1'b0, 8, 12);
        for (int i = 0; i < 2; i++) applyStimulus(1, 1'b0, 8, 12);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1'b1, 8, 12);
        for (int i = 0; i < 2; i++) applyStimulus(1, 1'b1, 8, 12);
        tick(100);
        checkVal("rect_home", {29'd0, step_err, idle, home}, 32'b011);

        // Snapshot request coinciding with a step event
        dir1 = 1'b0;
        tick(4);
        pul1 = 1'b0;
        tick(6);
        checkVal("pre_step_ack_idle", {30'd0, snap_bus.snap_ack, idle}, 32'b01);
        snap_bus.snap_req = 1'b1;
        tick(1);
        mx = 24'd1;
        checkVal("snap_ack_rise", {30'd0, snap_bus.snap_ack, idle}, 32'b10);
        checkVal("snap_x_pre_step", 32'(snap_bus.snap_x), 32'd0);
        checkVal("pos_x_post_step", 32'(pos_x), 32'(mx));
        tick(2);
        pul1 = 1'b1;
        tick(12);
        applyStimulus(0, 1'b0, 8, 12);
        checkVal("snap_x_held", {7'd0, snap_bus.snap_ack, snap_bus.snap_x}, {7'd0, 1'b1, 24'd0});
        snap_bus.snap_req = 1'b0;
        tick(1);
        checkVal("snap_ack_drop", {31'd0, snap_bus.snap_ack}, 32'd0);
        snap_bus.snap_req = 1'b1;
        tick(2);
        checkVal("snap_recapture", {7'd0, snap_bus.snap_ack, snap_bus.snap_x}, {7'd0, 1'b1, mx});
        snap_bus.snap_req = 1'b0;
        tick(2);

        // Wrap on a 4-bit position counter
        for (int i = 0; i < 7; i++) applyStimulus(2, 1'b0, 8, 12);
        checkVal("ovf_before_wrap", {31'd0, ovf4}, 32'd0);
        applyStimulus(2, 1'b0, 8, 12);
        checkVal("ovf_after_wrap", {31'd0, ovf4}, 32'd1);
        checkVal("ovf_main_clear", {31'd0, ovf}, 32'd0);

        // Reset in the middle of an acknowledged snapshot
        snap_bus.snap_req = 1'b1;
        tick(2);
        checkVal("ack_before_rst", {31'd0, snap_bus.snap_ack}, 32'd1);
        rst = 1'b1;
        #1;
        checkVal("rst_mid_ack", {31'd0, snap_bus.snap_ack}, 32'd0);
        checkVal("rst_mid_pos", {pos_x[15:0], 12'd0, pos_x4}, 32'd0);
        checkVal("rst_mid_flags", {30'd0, ovf4, idle}, 32'd0);
        tick(2);
        rst = 1'b0;
        snap_bus.snap_req = 1'b0;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
